// File: rtl/rbfu_pkg.sv
// Shared constants and types for the RBFU result path.
// Opcode encodings and the packed result-entry layout.
package rbfu_pkg;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 8;
  localparam int Q      = 3329;

  typedef enum logic [1:0] {
    OP_NTT  = 2'b00,
    OP_INTT = 2'b01,
    OP_PWM1 = 2'b10,
    OP_PWM2 = 2'b11
  } opcode_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    opcode_e           opcode;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous show-ahead FIFO for RBFU result entries.
// Head entry is visible whenever the FIFO is non-empty.
module wb_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 42,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop && !empty;
  assign head   = mem[rptr];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= nxt(wptr);
      if (do_pop) rptr <= nxt(rptr);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/rbfu_writeback.sv
// RBFU result writeback: tags issues through the RBFU latency,
// queues Dout pairs and hands them to coefficient memory in order.
module rbfu_writeback #(
  parameter int DATA_W   = rbfu_pkg::DATA_W,
  parameter int ADDR_W   = rbfu_pkg::ADDR_W,
  parameter int RBFU_LAT = 4,
  parameter int DEPTH    = 8,
  parameter int Q        = rbfu_pkg::Q
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] issue_addr0,
  input  logic [ADDR_W-1:0] issue_addr1,
  input  logic [1:0]        issue_opcode,
  input  logic [DATA_W-1:0] Dout1,
  input  logic [DATA_W-1:0] Dout2,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic [DATA_W-1:0] wr_data0,
  output logic [ADDR_W-1:0] wr_addr1,
  output logic [DATA_W-1:0] wr_data1,
  output logic [1:0]        wr_opcode,
  output logic              busy,
  output logic              range_err
);

  import rbfu_pkg::*;

  if (DEPTH < 2) begin : g_depth_chk
    $error("rbfu_writeback: DEPTH must be >= 2");
  end
  if (RBFU_LAT < 1) begin : g_lat_chk
    $error("rbfu_writeback: RBFU_LAT must be >= 1");
  end

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 2 * ADDR_W + 2 + 2 * DATA_W;

  logic [RBFU_LAT-1:0] tag_v;
  logic [ADDR_W-1:0]   tag_a0 [RBFU_LAT];
  logic [ADDR_W-1:0]   tag_a1 [RBFU_LAT];
  logic [1:0]          tag_op [RBFU_LAT];
  logic [CW-1:0]       inflight;
  logic [CW-1:0]       count;
  logic [CW:0]         used;
  logic [EW-1:0]       push_data;
  logic [EW-1:0]       head;
  logic                fire;
  logic                capture;
  logic                pop;
  logic                full;
  logic                empty;

  assign fire    = issue_valid && issue_ready;
  assign capture = tag_v[RBFU_LAT-1];
  assign pop     = wr_valid && wr_ready;

  // Credits cover both queued and in-flight results, so a capture
  // always finds a free FIFO slot.
  assign used        = {1'b0, count} + {1'b0, inflight};
  assign issue_ready = used < (CW + 1)'(DEPTH);
  assign busy        = (inflight != '0) || !empty;
  assign wr_valid    = !empty;

  assign push_data = {tag_a0[RBFU_LAT-1], tag_a1[RBFU_LAT-1],
                      tag_op[RBFU_LAT-1], Dout1, Dout2};

  assign {wr_addr0, wr_addr1, wr_opcode, wr_data0, wr_data1} =
    empty ? '0 : head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v    <= '0;
      inflight <= '0;
      for (int i = 0; i < RBFU_LAT; i++) begin
        tag_a0[i] <= '0;
        tag_a1[i] <= '0;
        tag_op[i] <= '0;
      end
    end else begin
      tag_v[0]  <= fire;
      tag_a0[0] <= issue_addr0;
      tag_a1[0] <= issue_addr1;
      tag_op[0] <= issue_opcode;
      for (int i = 1; i < RBFU_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_a0[i] <= tag_a0[i-1];
        tag_a1[i] <= tag_a1[i-1];
        tag_op[i] <= tag_op[i-1];
      end
      inflight <= inflight + CW'(fire) - CW'(capture);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_err <= 1'b0;
    end else if (capture &&
                 ({1'b0, Dout1} >= (DATA_W + 1)'(Q) ||
                  {1'b0, Dout2} >= (DATA_W + 1)'(Q))) begin
      range_err <= 1'b1;
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  a_no_overflow : assert property (
    @(posedge clk) disable iff (!rst_n) !(capture && full && !pop)
  );

endmodule

// File: tb/tb_rbfu_writeback.sv
// Directed bench for rbfu_writeback with a simple RBFU model
// and an in-order scoreboard of expected memory writes.
module tb_rbfu_writeback;

  import rbfu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [7:0]  issue_addr0;
  logic [7:0]  issue_addr1;
  logic [1:0]  issue_opcode;
  logic [11:0] Dout1;
  logic [11:0] Dout2;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_addr0;
  logic [11:0] wr_data0;
  logic [7:0]  wr_addr1;
  logic [11:0] wr_data1;
  logic [1:0]  wr_opcode;
  logic        busy;
  logic        range_err;

  int n_vec = 0;
  int n_err = 0;

  wb_entry_t exp_q[$];
  wb_entry_t cur;

  always #5 clk = ~clk;

  rbfu_writeback dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_addr0  (issue_addr0),
    .issue_addr1  (issue_addr1),
    .issue_opcode (issue_opcode),
    .Dout1        (Dout1),
    .Dout2        (Dout2),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr0     (wr_addr0),
    .wr_data0     (wr_data0),
    .wr_addr1     (wr_addr1),
    .wr_data1     (wr_data1),
    .wr_opcode    (wr_opcode),
    .busy         (busy),
    .range_err    (range_err)
  );

  assign cur = {wr_addr0, wr_addr1, wr_opcode, wr_data0, wr_data1};

  function automatic logic [11:0] d1_of(input logic [7:0] a);
    if (a == 8'hF0) return 12'd3329;
    if (a == 8'hF1) return 12'd3328;
    return 12'(a) * 12'd3;
  endfunction

  function automatic logic [11:0] d2_of(input logic [7:0] a);
    return 12'(a) * 12'd5 + 12'd7;
  endfunction

  function automatic wb_entry_t mk(input logic [7:0] a0, a1,
                                   input logic [1:0] op);
    wb_entry_t e;
    e.addr0  = a0;
    e.addr1  = a1;
    e.opcode = opcode_e'(op);
    e.data0  = d1_of(a0);
    e.data1  = d2_of(a0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RBFU model: Dout pair appears RBFU_LAT cycles after operand sampling.
  logic [7:0] rb_a [4];
  logic [3:0] rb_v;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_v <= '0;
    end else begin
      rb_v     <= {rb_v[2:0], issue_valid && issue_ready};
      rb_a[0]  <= issue_addr0;
      for (int i = 1; i < 4; i++) rb_a[i] <= rb_a[i-1];
    end
  end

  assign Dout1 = rb_v[3] ? d1_of(rb_a[3]) : 12'h0;
  assign Dout2 = rb_v[3] ? d2_of(rb_a[3]) : 12'h0;

  always @(negedge clk) begin
    if (rst_n && wr_valid && wr_ready) begin
      if (exp_q.size() == 0) chk("extra_write", 64'(cur), 64'hDEAD);
      else chk("wr_pair", 64'(cur), 64'(exp_q.pop_front()));
    end
  end

  logic      hstall = 1'b0;
  wb_entry_t hprev;

  always @(negedge clk) begin
    if (rst_n && hstall) chk("hold", 64'(cur), 64'(hprev));
    hstall <= rst_n && wr_valid && !wr_ready;
    hprev  <= cur;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input logic [7:0] a0, a1,
                           input logic [1:0] op, input bit acc);
    issue_valid  = 1'b1;
    issue_addr0  = a0;
    issue_addr1  = a1;
    issue_opcode = op;
    if (acc) exp_q.push_back(mk(a0, a1, op));
    tick();
  endtask

  task automatic idle_in();
    issue_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit toggle);
    for (int i = 0; i < 60 && busy; i++) begin
      if (toggle) wr_ready = ~wr_ready;
      tick();
    end
    wr_ready = 1'b1;
    tick();
    chk("idle", 64'(busy), 64'd0);
    chk("drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst_n        = 1'b1;
    issue_valid  = 1'b0;
    issue_addr0  = '0;
    issue_addr1  = '0;
    issue_opcode = '0;
    wr_ready     = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(issue_ready), 64'd1);
    chk("rst_range", 64'(range_err), 64'd0);
    chk("rst_wr_bus", 64'(cur), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wr_ready = 1'b1;

    // first write appears 4 edges after the fire edge
    issue_one(8'h10, 8'h90, 2'b00, 1'b1);
    idle_in();
    for (int k = 1; k <= 4; k++) begin
      tick();
      @(negedge clk);
      chk("latency", 64'(wr_valid), 64'(k == 4));
    end
    wait_idle(1'b0);

    // streaming
    for (int i = 0; i < 8; i++) begin
      chk("stream_rdy", 64'(issue_ready), 64'd1);
      issue_one(8'(8'h20 + i), 8'(8'hA0 + i), 2'(i), 1'b1);
    end
    idle_in();
    wait_idle(1'b0);

    // opcode tags back-to-back
    issue_one(8'h30, 8'h31, OP_NTT, 1'b1);
    issue_one(8'h32, 8'h33, OP_INTT, 1'b1);
    issue_one(8'h34, 8'h35, OP_PWM1, 1'b1);
    issue_one(8'h36, 8'h37, OP_PWM2, 1'b1);
    idle_in();
    wait_idle(1'b0);

    // backpressure: only DEPTH issues accepted
    wr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rdy", 64'(issue_ready), 64'(i < 8));
      issue_one(8'(8'h50 + i), 8'(8'hD0 + i), 2'b01, i < 8);
    end
    idle_in();
    for (int i = 0; i < 6; i++) tick();
    chk("bp_busy", 64'(busy), 64'd1);
    chk("bp_full_rdy", 64'(issue_ready), 64'd0);
    wr_ready = 1'b1;
    wait_idle(1'b0);
    chk("bp_ready_back", 64'(issue_ready), 64'd1);

    // hold under toggling wr_ready
    for (int i = 0; i < 6; i++) begin
      wr_ready = i[0];
      issue_one(8'(8'h70 + i), 8'(8'hE0 + i), 2'(i), 1'b1);
    end
    idle_in();
    wait_idle(1'b1);

    // range checker
    issue_one(8'hF1, 8'h01, OP_NTT, 1'b1);
    idle_in();
    wait_idle(1'b0);
    chk("range_3328", 64'(range_err), 64'd0);
    issue_one(8'hF0, 8'h02, OP_NTT, 1'b1);
    idle_in();
    for (int k = 1; k <= 4; k++) begin
      tick();
      @(negedge clk);
      chk("range_3329", 64'(range_err), 64'(k == 4));
    end
    wait_idle(1'b0);
    chk("range_sticky", 64'(range_err), 64'd1);

    // reset with 4 queued and 3 in flight
    wr_ready = 1'b0;
    for (int i = 0; i < 7; i++)
      issue_one(8'(8'h40 + i), 8'(8'hC0 + i), 2'b10, 1'b1);
    idle_in();
    tick();
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_wr_valid", 64'(wr_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_wr_valid", 64'(wr_valid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_ready", 64'(issue_ready), 64'd1);
    chk("mrst_range", 64'(range_err), 64'd0);
    exp_q.delete();
    tick();
    rst_n    = 1'b1;
    wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      chk("stale", 64'(wr_valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
